// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU operation codes, immediate formats
// and the control-signal bundle carried in the ID/EX register.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;
    localparam logic [3:0] ALU_DIV    = 4'd14;
    localparam logic [3:0] ALU_DIVU   = 4'd15;
    // Only 16 codes exist: REM/REMU share the divider codes, funct3[1] selects remainder.
    localparam logic [3:0] ALU_REM    = ALU_DIV;
    localparam logic [3:0] ALU_REMU   = ALU_DIVU;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic alu_src_imm;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic illegal;
    } ctrl_t;

    function automatic logic [3:0] alu_base(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] alu_m(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return ALU_MUL;
            3'd1:    return ALU_MULH;
            3'd2:    return ALU_MULHSU;
            3'd3:    return ALU_MULHU;
            3'd4:    return ALU_DIV;
            3'd5:    return ALU_DIVU;
            3'd6:    return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the RV32 I/S/B/U/J formats.
// Only instruction bits 31:7 carry immediate or register fields, so bits 6:0 are not taken.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7]     instr_i,
    input  imm_fmt_e        format_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        case (format_i)
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: registered ID/EX bundle, load-use hazard bubble, flush and hold.
// Define DECODE_RV32M_EN to accept the RV32M multiply/divide encodings.
module decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     instr_in,
    input  logic [XLEN-1:0]     pc4_in,
    input  logic                valid_in,
    input  logic                flush,
    input  logic                stall_in,
    output logic                hazard_stall,
    output logic                valid_out,
    output logic [XLEN-1:0]     pc4_out,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                jal,
    output logic                jalr,
    output logic                lui,
    output logic                auipc,
    output logic [2:0]          funct3,
    output logic                illegal
);
    import riscv_pkg::*;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc4;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          funct3;
        ctrl_t               ctrl;
    } id_ex_t;

    id_ex_t          id_ex_q, id_ex_d, dec;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm_val;
    logic            rs1_used, rs2_used, legal;
    logic [6:0]      opcode, funct7;
    logic [2:0]      f3;

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    imm_gen u_imm_gen (
        .instr_i  (instr_in[31:7]),
        .format_i (fmt),
        .imm_o    (imm_val)
    );

    always_comb begin
        dec        = '0;
        fmt        = IMM_I;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        legal      = 1'b1;
        dec.valid  = valid_in;
        dec.pc4    = pc4_in;
        dec.rs1    = instr_in[19:15];
        dec.rs2    = instr_in[24:20];
        dec.rd     = instr_in[11:7];
        dec.funct3 = f3;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec.ctrl.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_op = alu_base(f3, 1'b0);
                end else if (funct7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    dec.alu_op = alu_base(f3, 1'b1);
                end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    dec.alu_op = alu_m(f3);
`else
                    legal = 1'b0;
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                rs1_used             = 1'b1;
                dec.ctrl.reg_write   = 1'b1;
                dec.ctrl.alu_src_imm = 1'b1;
                dec.alu_op           = alu_base(f3, 1'b0);
                if (f3 == 3'd1) begin
                    legal = (instr_in[31:26] == 6'b000000);
                end else if (f3 == 3'd5) begin
                    legal      = (instr_in[31:26] == 6'b000000) || (instr_in[31:26] == 6'b010000);
                    dec.alu_op = alu_base(f3, instr_in[30]);
                end
            end
            OPC_LOAD: begin
                rs1_used             = 1'b1;
                dec.ctrl.reg_write   = 1'b1;
                dec.ctrl.mem_read    = 1'b1;
                dec.ctrl.alu_src_imm = 1'b1;
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            OPC_STORE: begin
                rs1_used             = 1'b1;
                rs2_used             = 1'b1;
                fmt                  = IMM_S;
                dec.ctrl.mem_write   = 1'b1;
                dec.ctrl.alu_src_imm = 1'b1;
                legal = (f3 <= 3'd2);
            end
            OPC_BRANCH: begin
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                fmt             = IMM_B;
                dec.ctrl.branch = 1'b1;
                dec.alu_op      = ALU_SUB;
                legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OPC_JAL: begin
                fmt                = IMM_J;
                dec.ctrl.jal       = 1'b1;
                dec.ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                rs1_used             = 1'b1;
                dec.ctrl.jalr        = 1'b1;
                dec.ctrl.reg_write   = 1'b1;
                dec.ctrl.alu_src_imm = 1'b1;
                legal = (f3 == 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt                  = IMM_U;
                dec.ctrl.lui         = (opcode == OPC_LUI);
                dec.ctrl.auipc       = (opcode == OPC_AUIPC);
                dec.ctrl.reg_write   = 1'b1;
                dec.ctrl.alu_src_imm = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings still produce a valid bundle, but with no side effects.
        if (!legal) begin
            dec.ctrl         = '0;
            dec.ctrl.illegal = 1'b1;
            dec.alu_op       = ALU_ADD;
        end
        if (!valid_in) begin
            dec.ctrl = '0;
        end
    end

    assign hazard_stall = !rst && !flush && valid_in && id_ex_q.valid && id_ex_q.ctrl.mem_read
                          && (id_ex_q.rd != 5'd0)
                          && ((rs1_used && instr_in[19:15] == id_ex_q.rd)
                           || (rs2_used && instr_in[24:20] == id_ex_q.rd));

    always_comb begin
        id_ex_d = id_ex_q;
        if (!stall_in) begin
            if (flush || hazard_stall) begin
                id_ex_d = '0;
            end else begin
                id_ex_d     = dec;
                id_ex_d.imm = imm_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign valid_out   = id_ex_q.valid;
    assign pc4_out     = id_ex_q.pc4;
    assign rs1         = id_ex_q.rs1;
    assign rs2         = id_ex_q.rs2;
    assign rd          = id_ex_q.rd;
    assign imm         = id_ex_q.imm;
    assign alu_op      = id_ex_q.alu_op;
    assign funct3      = id_ex_q.funct3;
    assign alu_src_imm = id_ex_q.ctrl.alu_src_imm;
    assign reg_write   = id_ex_q.ctrl.reg_write;
    assign mem_read    = id_ex_q.ctrl.mem_read;
    assign mem_write   = id_ex_q.ctrl.mem_write;
    assign branch      = id_ex_q.ctrl.branch;
    assign jal         = id_ex_q.ctrl.jal;
    assign jalr        = id_ex_q.ctrl.jalr;
    assign lui         = id_ex_q.ctrl.lui;
    assign auipc       = id_ex_q.ctrl.auipc;
    assign illegal     = id_ex_q.ctrl.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction-decode pipeline stage. It consumes the registered instruction and PC+4 produced by the fetch stage. It produces a registered ID/EX bundle of register indices, sign-extended immediate, control signals and PC+4. It detects load-use hazards and back-pressures fetch with a one-cycle stall, and it honours flush requests from branch resolution. RV32I base; RV32M decode is optional.

Parameters:
XLEN, 32, datapath and instruction width.
ALU_OP_W, 4, width of the alu_op encoding.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
instr_in  in  32  instruction from fetch.
pc4_in  in  32  PC+4 of instr_in.
valid_in  in  1  instr_in/pc4_in hold a real instruction.
flush  in  1  squash the instruction currently entering decode (taken branch/jump).
stall_in  in  1  downstream hold; freeze the ID/EX register.
hazard_stall  out  1  combinational; fetch must hold the PC and its output register this cycle.
valid_out  out  1  ID/EX bundle is valid.
pc4_out  out  32  registered pc4_in.
rs1, rs2, rd  out  5 each  register indices.
imm  out  32  sign-extended immediate (I/S/B/U/J).
alu_op  out  4  ALU operation code (package encoding).
alu_src_imm  out  1  ALU operand B is imm.
reg_write, mem_read, mem_write, branch, jal, jalr, lui, auipc  out  1 each  control.
funct3  out  3  passed through for branch/load/store width.
illegal  out  1  valid instruction with an unsupported opcode or funct.

Behaviour:
- Reset (rst=1 at posedge): every output register is cleared to 0, including valid_out, imm, pc4_out and all controls. The internal load-tracking state is cleared.
- Latency: 1 cycle. A bundle decoded from instr_in at edge N appears on the outputs after edge N.
- Per-edge priority: rst > stall_in > flush > hazard > normal.
  - stall_in=1: all outputs hold. hazard_stall is still computed.
  - flush=1: valid_out<=0 and all controls<=0 (bubble). Fields are don't-care.
  - hazard: hazard_stall = valid_in & valid_out & mem_read & (rd!=0) & ((rs1_used & rs1_in==rd) | (rs2_used & rs2_in==rd)). When asserted, the stage inserts a bubble (valid_out<=0, controls 0) and does not consume instr_in. Fetch re-presents the same instruction next cycle.
  - normal: register the decoded bundle, with valid_out<=valid_in.
- hazard_stall is forced to 0 when flush=1 or rst=1.
- A bubble never asserts reg_write, mem_read, mem_write, branch, jal or jalr.
- rs1_used: all formats except U and J. rs2_used: R, S, B.
- Immediates:
  - I = {20{i[31]}, i[31:20]}
  - S = {20{i[31]}, i[31:25], i[11:7]}
  - B = {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - U = {i[31:12], 12'b0}
  - J = {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
- R-type and OP-IMM: alu_op follows funct3/funct7[5].
- SRAI/SRLI with i[31:26] other than 000000/010000: illegal=1, reg_write=0.
- Unknown opcode with valid_in=1: illegal=1, valid_out=1, all other controls 0.
- rd=0: reg_write is still reported. Writeback ignores x0.

Optional Feature:
DECODE_RV32M_EN.
- Defined: OP with funct7=0000001 decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. alu_op takes the package M codes, reg_write=1.
- Undefined: the same encodings give illegal=1, reg_write=0.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - the alu_op encoding constants, including M codes
  - an imm-format enum (IMM_I/S/B/U/J)
  - the XLEN constant
- One sub-module: imm_gen, combinational. Inputs are instr and format; output is the 32-bit imm.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_in=1 and instr_in=0x00500093. Required: all outputs 0 and hazard_stall=0. First edge after rst drops: valid_out=1, rd=1, rs1=0, imm=5, alu_op=ADD, alu_src_imm=1, reg_write=1.
- Branch immediate: instr_in=0xFE000CE3 (beq x0,x0,-8). Required: imm=0xFFFFFFF8, branch=1, funct3=0, reg_write=0.
- Load-use hazard: lw x2,0(x1)=0x0000A103, then add x3,x2,x1=0x001101B3. Required: hazard_stall=1 for exactly one cycle, one bubble with valid_out=0, then the add bundle with rs1=2, rs2=1, rd=3.
- Flush vs hazard: repeat the load-use case with flush=1 in the hazard cycle. Required: hazard_stall=0 and a bubble is issued.
- stall_in held 3 cycles mid-stream. Required: outputs frozen; next instruction appears one cycle after stall_in falls.
- RV32M: 0x027302B3 (mul x5,x6,x7). With DECODE_RV32M_EN: alu_op=MUL, illegal=0. Without it: illegal=1, reg_write=0.
